// File: rtl/lfsr_digit_gen_if.sv
// Request/valid/ack bus of the LFSR digit generator, plus seed loading and debug state.
// The master drives requests and seeds; the slave (generator) returns the digits.
interface lfsr_digit_gen_if #(
    parameter int LFSR_W     = 16,
    parameter int NUM_DIGITS = 4
);
    logic                    seed_load;
    logic [LFSR_W-1:0]       seed_in;
    logic                    req;
    logic                    hex_mode;
    logic                    ack;
    logic                    busy;
    logic                    valid;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [LFSR_W-1:0]       lfsr_state;

    modport master (
        output seed_load, seed_in, req, hex_mode, ack,
        input  busy, valid, digits, lfsr_state
    );

    modport slave (
        input  seed_load, seed_in, req, hex_mode, ack,
        output busy, valid, digits, lfsr_state
    );
endinterface

// File: rtl/lfsr_digit_gen.sv
// Galois-LFSR random digit generator: on request, builds NUM_DIGITS 4-bit digits serially,
// one per cycle, each either a raw nibble or a nibble scaled into 0-9.
module lfsr_digit_gen #(
    parameter int                LFSR_W     = 16,
    parameter int                NUM_DIGITS = 4,
    parameter logic [LFSR_W-1:0] TAPS       = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED       = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    lfsr_digit_gen_if.slave    bus
);
    localparam int                CNT_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [LFSR_W-1:0] SEED_SAFE = (SEED == '0) ? LFSR_W'(1) : SEED;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

    state_t            state_q;
    logic [LFSR_W-1:0] lfsr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              mode_q;
    logic              busy_q;
    logic              valid_q;
    logic [3:0]        digit_q [NUM_DIGITS];

    logic [LFSR_W-1:0] step1_d;
    logic [LFSR_W-1:0] step4_d;
    logic [LFSR_W-1:0] seed_d;
    logic [7:0]        scaled_d;
    logic [3:0]        digit_d;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : '0);
    endfunction

    always_comb begin
        step1_d = lfsr_step(lfsr_q);
        step4_d = lfsr_q;
        for (int i = 0; i < 4; i++) begin
            step4_d = lfsr_step(step4_d);
        end
        seed_d = (bus.seed_in == '0) ? LFSR_W'(1) : bus.seed_in;
        // Decimal scaling keeps the top nibble of n*10, so 15 maps to 9 and nothing exceeds 9.
        scaled_d = {4'b0000, step4_d[3:0]} * 8'd10;
        digit_d  = mode_q ? step4_d[3:0] : scaled_d[7:4];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            lfsr_q  <= SEED_SAFE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= 4'h0;
            end
        end else if (bus.seed_load) begin
            // Seeding aborts any request in flight but leaves the last digits visible.
            lfsr_q  <= seed_d;
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    lfsr_q <= step1_d;
                    if (bus.req) begin
                        mode_q  <= bus.hex_mode;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= GEN;
                    end
                end
                GEN: begin
                    lfsr_q         <= step4_d;
                    digit_q[cnt_q] <= digit_d;
                    if (cnt_q == CNT_LAST) begin
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    lfsr_q <= step1_d;
                    if (bus.ack) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (lfsr_q == '0) begin
                lfsr_q <= LFSR_W'(1);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digits
            assign bus.digits[4*gi +: 4] = digit_q[gi];
        end
    endgenerate

    assign bus.busy       = busy_q;
    assign bus.valid      = valid_q;
    assign bus.lfsr_state = lfsr_q;
endmodule

// File: tb/tb_lfsr_digit_gen.sv
// Directed bench for lfsr_digit_gen: known vectors, handshake, abort/reset, decimal range and LFSR period.
module tb_lfsr_digit_gen;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    lfsr_digit_gen_if #(.LFSR_W(16), .NUM_DIGITS(4)) bus ();

    lfsr_digit_gen #(
        .LFSR_W(16), .NUM_DIGITS(4), .TAPS(16'hB400), .SEED(16'hACE1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.seed_load = 1'b0;
        bus.seed_in   = 16'h0000;
        bus.req       = 1'b0;
        bus.hex_mode  = 1'b0;
        bus.ack       = 1'b0;
    endtask

    task automatic load_seed(input logic [15:0] s);
        bus.seed_load = 1'b1;
        bus.seed_in   = s;
        tick();
        bus.seed_load = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        checks++;
        if (bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.digits !== 16'h0000 || bus.lfsr_state !== 16'hACE1) begin
            errors++;
            $display("FAIL reset: valid=%b busy=%b digits=%h lfsr=%h, expected 0 0 0000 ace1",
                     bus.valid, bus.busy, bus.digits, bus.lfsr_state);
        end
        rst = 1'b1;
        $display("reset: lfsr=%h digits=%h", bus.lfsr_state, bus.digits);
    endtask

    task automatic test_known_vector(input logic hex, input logic [15:0] exp_digits);
        int busy_cycles = 0;
        load_seed(16'hACE1);
        bus.req = 1'b1;
        bus.hex_mode = hex;
        tick();
        bus.req = 1'b0;
        bus.hex_mode = ~hex;
        checks++;
        if (bus.lfsr_state !== 16'hE270 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL accept_hex%0b: lfsr=%h busy=%b, expected e270 1", hex, bus.lfsr_state, bus.busy);
        end
        for (int i = 0; i < 10 && bus.busy === 1'b1; i++) begin
            busy_cycles++;
            tick();
        end
        checks++;
        if (busy_cycles != 4 || bus.valid !== 1'b1 || bus.digits !== exp_digits || bus.lfsr_state !== 16'h75B1) begin
            errors++;
            $display("FAIL result_hex%0b: busy_cycles=%0d valid=%b digits=%h lfsr=%h, expected 4 1 %h 75b1",
                     hex, busy_cycles, bus.valid, bus.digits, bus.lfsr_state, exp_digits);
        end
        $display("known vector hex=%0b: digits=%h lfsr=%h", hex, bus.digits, bus.lfsr_state);
    endtask

    task automatic test_handshake();
        logic [15:0] held;
        test_known_vector(1'b1, 16'h1627);
        held = bus.digits;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (bus.valid !== 1'b1 || bus.digits !== held) begin
                errors++;
                $display("FAIL hold_%0d: valid=%b digits=%h, expected 1 %h", i, bus.valid, bus.digits, held);
            end
        end
        bus.ack = 1'b1;
        bus.req = 1'b1;
        tick();
        bus.ack = 1'b0;
        bus.req = 1'b0;
        checks++;
        if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL ack_with_req: valid=%b busy=%b, expected 0 0", bus.valid, bus.busy);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.digits !== held) begin
            errors++;
            $display("FAIL no_new_gen: busy=%b digits=%h, expected 0 %h", bus.busy, bus.digits, held);
        end
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL rereq: busy=%b, expected 1", bus.busy);
        end
        $display("handshake: held digits=%h, re-request busy=%b", held, bus.busy);
    endtask

    task automatic test_seed_zero_abort();
        tick();
        tick();
        bus.seed_load = 1'b1;
        bus.seed_in   = 16'h0000;
        bus.req       = 1'b1;
        tick();
        bus.seed_load = 1'b0;
        bus.req       = 1'b0;
        checks++;
        if (bus.lfsr_state !== 16'h0001 || bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL seed_zero: lfsr=%h busy=%b valid=%b, expected 0001 0 0",
                     bus.lfsr_state, bus.busy, bus.valid);
        end
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        checks++;
        if (bus.lfsr_state !== 16'hB400 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL after_abort_req: lfsr=%h busy=%b, expected b400 1", bus.lfsr_state, bus.busy);
        end
        for (int i = 0; i < 4; i++) tick();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        $display("seed zero abort: lfsr after reload=0001, restart ok");
    endtask

    task automatic test_reset_mid_gen();
        load_seed(16'h1234);
        bus.req = 1'b1;
        bus.hex_mode = 1'b0;
        tick();
        bus.req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++;
        if (bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.digits !== 16'h0000 || bus.lfsr_state !== 16'hACE1) begin
            errors++;
            $display("FAIL mid_gen_reset: valid=%b busy=%b digits=%h lfsr=%h, expected 0 0 0000 ace1",
                     bus.valid, bus.busy, bus.digits, bus.lfsr_state);
        end
        bus.req = 1'b1;
        bus.hex_mode = 1'b1;
        tick();
        bus.req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (bus.valid !== 1'b1 || bus.digits !== 16'h1627) begin
            errors++;
            $display("FAIL fresh_after_reset: valid=%b digits=%h, expected 1 1627", bus.valid, bus.digits);
        end
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        $display("reset mid-gen: fresh digits=%h", bus.digits);
    endtask

    task automatic test_decimal_sweep();
        int bad = 0;
        int timeouts = 0;
        logic [3:0] nib;
        for (int r = 0; r < 1000; r++) begin
            bus.req = 1'b1;
            bus.hex_mode = 1'b0;
            tick();
            bus.req = 1'b0;
            for (int w = 0; w < 10 && bus.valid !== 1'b1; w++) tick();
            if (bus.valid !== 1'b1) timeouts++;
            for (int k = 0; k < 4; k++) begin
                nib = bus.digits[4*k +: 4];
                if (nib > 4'd9) bad++;
            end
            bus.ack = 1'b1;
            tick();
            bus.ack = 1'b0;
        end
        checks++;
        if (bad != 0 || timeouts != 0) begin
            errors++;
            $display("FAIL decimal_sweep: digits_over_9=%0d timeouts=%0d, expected 0 0", bad, timeouts);
        end
        $display("decimal sweep: 1000 requests, over_9=%0d timeouts=%0d", bad, timeouts);
    endtask

    task automatic test_period();
        int zeros = 0;
        int early = 0;
        load_seed(16'hACE1);
        for (int i = 1; i <= 65535; i++) begin
            tick();
            if (bus.lfsr_state === 16'h0000) zeros++;
            if (i < 65535 && bus.lfsr_state === 16'hACE1) early++;
        end
        checks++;
        if (bus.lfsr_state !== 16'hACE1 || zeros != 0 || early != 0) begin
            errors++;
            $display("FAIL period: lfsr=%h zeros=%0d early_returns=%0d, expected ace1 0 0",
                     bus.lfsr_state, zeros, early);
        end
        $display("period: lfsr after 65535 steps=%h zeros=%0d", bus.lfsr_state, zeros);
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_known_vector(1'b1, 16'h1627);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        checks++;
        if (bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL ack_clears_valid: valid=%b, expected 0", bus.valid);
        end
        test_known_vector(1'b0, 16'h0314);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        test_handshake();
        test_seed_zero_abort();
        test_reset_mid_gen();
        test_decimal_sweep();
        test_period();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
